// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU operand capture stage.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_MOD = 3'd4
  } op_e;

  // Any opcode above this value is illegal and is dropped on accept.
  localparam logic [2:0] OP_LAST = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [2:0]        op;
    logic              zero;
  } operand_entry_t;

endpackage

// File: rtl/alu_operand_fifo.sv
// DEPTH-entry synchronous FIFO of operand entries with occupancy, full and empty.
module alu_operand_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  operand_entry_t         wdata_i,
  input  logic                   pop_i,
  output operand_entry_t         rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  operand_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W-1:0]   w_last_ptr;
  logic               w_push;
  logic               w_pop;

  assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // When empty the slot behind the read pointer still holds the last entry
  // shown; a push into an empty FIFO writes at rd_ptr, so that slot survives.
  assign w_last_ptr = r_rd_ptr - 1'b1;
  assign rdata_o    = empty_o ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata_i;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand capture/dispatch stage: validates opcodes, tags zero operands, buffers in a FIFO.
// Optional statistics counters are enabled with the ALU_OPERAND_STATS_EN macro.
module alu_operand_stage #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_W-1:0]      data0_i,
  input  logic [DATA_W-1:0]      data1_i,
  input  logic [2:0]             op_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      data0_o,
  output logic [DATA_W-1:0]      data1_o,
  output logic [2:0]             op_o,
  output logic                   zero_o,
  output logic                   illegal_o,
  output logic [$clog2(DEPTH):0] count_o
`ifdef ALU_OPERAND_STATS_EN
  ,
  output logic [15:0]            accepted_cnt_o,
  output logic [15:0]            dropped_cnt_o
`endif
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready_o depends only on stored occupancy (never on
  // out_ready_i), so a full FIFO refuses a push even when it pops that cycle.
  // out_valid_o is high whenever an entry is stored; outputs hold until popped.

  alu_pkg::operand_entry_t w_wentry;
  alu_pkg::operand_entry_t w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_legal;
  logic                    w_push;
  logic                    w_pop;
  logic                    r_illegal;

  assign in_ready_o  = ~w_full;
  assign out_valid_o = ~w_empty;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_legal     = (op_i <= alu_pkg::OP_LAST);
  assign w_push      = w_accept & w_legal;
  assign w_pop       = out_valid_o & out_ready_i;

  assign w_wentry.data0 = data0_i;
  assign w_wentry.data1 = data1_i;
  assign w_wentry.op    = op_i;
  assign w_wentry.zero  = (data0_i == '0) || (data1_i == '0);

  alu_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .wdata_i (w_wentry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (count_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign data0_o   = w_head.data0;
  assign data1_o   = w_head.data1;
  assign op_o      = w_head.op;
  assign zero_o    = w_head.zero;
  assign illegal_o = r_illegal;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_illegal <= 1'b0;
    else         r_illegal <= w_accept & ~w_legal;
  end

`ifdef ALU_OPERAND_STATS_EN
  logic [15:0] r_accepted_cnt;
  logic [15:0] r_dropped_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_accepted_cnt <= '0;
      r_dropped_cnt  <= '0;
    end else begin
      if (w_push && r_accepted_cnt != 16'hFFFF) r_accepted_cnt <= r_accepted_cnt + 16'd1;
      if (w_accept && !w_legal && r_dropped_cnt != 16'hFFFF) r_dropped_cnt <= r_dropped_cnt + 16'd1;
    end
  end

  assign accepted_cnt_o = r_accepted_cnt;
  assign dropped_cnt_o  = r_dropped_cnt;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a random run against a queue model.
module tb_alu_operand_stage;

  localparam int DEPTH = 2;
  localparam int EW    = 20;  // {data0[7:0], data1[7:0], op[2:0], zero}

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] data0_i = '0;
  logic [7:0] data1_i = '0;
  logic [2:0] op_i = '0;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] data0_o;
  logic [7:0] data1_o;
  logic [2:0] op_o;
  logic       zero_o;
  logic       illegal_o;
  logic [1:0] count_o;
`ifdef ALU_OPERAND_STATS_EN
  logic [15:0] accepted_cnt_o;
  logic [15:0] dropped_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: stored legal entries in order, the last entry that left
  // the head (shown while empty), and the expected illegal pulse.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_pop = '0;
  logic          exp_illegal = 1'b0;

  alu_operand_stage #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data0_i     (data0_i),
    .data1_i     (data1_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data0_o     (data0_o),
    .data1_o     (data1_o),
    .op_o        (op_o),
    .zero_o      (zero_o),
    .illegal_o   (illegal_o),
    .count_o     (count_o)
`ifdef ALU_OPERAND_STATS_EN
    ,
    .accepted_cnt_o (accepted_cnt_o),
    .dropped_cnt_o  (dropped_cnt_o)
`endif
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] mk(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    return {a, b, op, (a == 8'd0) || (b == 8'd0)};
  endfunction

  function automatic logic [EW-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : last_pop;
  endfunction

  function automatic logic [EW-1:0] dut_head();
    return {data0_o, data1_o, op_o, zero_o};
  endfunction

  // Driver: called at a falling edge, presents one cycle of inputs, advances
  // the model across the rising edge and returns at the next falling edge.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic rdy);
    logic acc, pop;
    in_valid_i = v; data0_i = a; data1_i = b; op_i = op; out_ready_i = rdy;
    acc = v && (exp_q.size() < DEPTH);
    pop = rdy && (exp_q.size() != 0);
    @(posedge clk_i);
    if (pop) last_pop = exp_q.pop_front();
    if (acc && op <= 3'd4) exp_q.push_back(mk(a, b, op));
    exp_illegal = acc && (op > 3'd4);
    @(negedge clk_i);
    in_valid_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_pop    = '0;
    exp_illegal = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b exp 0", out_valid_o); end
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d exp 0", count_o); end
    total++; if (dut_head() !== '0) begin bad++; $display("FAIL reset_head: got %h exp 0", dut_head()); end
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %b exp 0", illegal_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_single_push();
    step(1'b1, 8'd17, 8'd5, 3'd4, 1'b0);
    total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b exp 1", out_valid_o); end
    total++; if (dut_head() !== {8'd17, 8'd5, 3'd4, 1'b0}) begin bad++; $display("FAIL single_head: got %h exp %h", dut_head(), {8'd17, 8'd5, 3'd4, 1'b0}); end
    total++; if (count_o !== 2'd1) begin bad++; $display("FAIL single_count: got %0d exp 1", count_o); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
  endtask

  task automatic test_zero_operand();
    step(1'b1, 8'd9, 8'd0, 3'd4, 1'b0);
    total++; if (zero_o !== 1'b1) begin bad++; $display("FAIL zero_flag: got %b exp 1", zero_o); end
    total++; if (dut_head() !== exp_head()) begin bad++; $display("FAIL zero_head: got %h exp %h", dut_head(), exp_head()); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL zero_pop_count: got %0d exp 0", count_o); end
    total++; if (dut_head() !== {8'd9, 8'd0, 3'd4, 1'b1}) begin bad++; $display("FAIL empty_hold: got %h exp %h", dut_head(), {8'd9, 8'd0, 3'd4, 1'b1}); end
  endtask

  task automatic test_fill();
    step(1'b1, 8'd1, 8'd1, 3'd0, 1'b0);
    step(1'b1, 8'd2, 8'd2, 3'd1, 1'b0);
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL full_ready: got %b exp 0", in_ready_o); end
    total++; if (count_o !== 2'd2) begin bad++; $display("FAIL full_count: got %0d exp 2", count_o); end
    step(1'b1, 8'd3, 8'd3, 3'd2, 1'b0);
    total++; if (count_o !== 2'd2) begin bad++; $display("FAIL held_count: got %0d exp 2", count_o); end
    total++; if (dut_head() !== {8'd1, 8'd1, 3'd0, 1'b0}) begin bad++; $display("FAIL held_head: got %h exp %h", dut_head(), {8'd1, 8'd1, 3'd0, 1'b0}); end
    // Push offered while full and popping: must be refused.
    step(1'b1, 8'd3, 8'd3, 3'd2, 1'b1);
    total++; if (dut_head() !== {8'd2, 8'd2, 3'd1, 1'b0}) begin bad++; $display("FAIL fill_pop_head: got %h exp %h", dut_head(), {8'd2, 8'd2, 3'd1, 1'b0}); end
    total++; if (count_o !== 2'd1) begin bad++; $display("FAIL full_pop_count: got %0d exp 1", count_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_back: got %b exp 1", in_ready_o); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL fill_drain_count: got %0d exp 0", count_o); end
  endtask

  task automatic test_illegal();
    step(1'b1, 8'd4, 8'd4, 3'd6, 1'b0);
    total++; if (illegal_o !== 1'b1) begin bad++; $display("FAIL illegal_pulse: got %b exp 1", illegal_o); end
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL illegal_count: got %0d exp 0", count_o); end
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL illegal_valid: got %b exp 0", out_valid_o); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    total++; if (illegal_o !== 1'b0) begin bad++; $display("FAIL illegal_one_cycle: got %b exp 0", illegal_o); end
    // Illegal push together with a pop: occupancy drops by one.
    step(1'b1, 8'd7, 8'd8, 3'd3, 1'b0);
    step(1'b1, 8'd1, 8'd2, 3'd7, 1'b1);
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL illegal_pop_count: got %0d exp 0", count_o); end
    total++; if (illegal_o !== 1'b1) begin bad++; $display("FAIL illegal_pop_pulse: got %b exp 1", illegal_o); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i), 8'(i), 3'd0, 1'b1);
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b exp 1", i, out_valid_o); end
      total++; if (dut_head() !== mk(8'(i), 8'(i), 3'd0)) begin bad++; $display("FAIL stream_head[%0d]: got %h exp %h", i, dut_head(), mk(8'(i), 8'(i), 3'd0)); end
      total++; if (count_o !== 2'd1) begin bad++; $display("FAIL stream_count[%0d]: got %0d exp 1", i, count_o); end
    end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL stream_end_count: got %0d exp 0", count_o); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 8'd11, 8'd12, 3'd1, 1'b0);
    step(1'b1, 8'd13, 8'd14, 3'd2, 1'b0);
    total++; if (count_o !== 2'd2) begin bad++; $display("FAIL pre_reset_count: got %0d exp 2", count_o); end
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL async_valid: got %b exp 0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL async_ready: got %b exp 1", in_ready_o); end
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL async_count: got %0d exp 0", count_o); end
    total++; if (dut_head() !== '0) begin bad++; $display("FAIL async_head: got %h exp 0", dut_head()); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b exp 0", out_valid_o); end
    step(1'b1, 8'd21, 8'd22, 3'd3, 1'b0);
    total++; if (dut_head() !== mk(8'd21, 8'd22, 3'd3)) begin bad++; $display("FAIL post_reset_head: got %h exp %h", dut_head(), mk(8'd21, 8'd22, 3'd3)); end
    step(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
  endtask

  task automatic test_random();
    logic       v, rdy;
    logic [7:0] a, b;
    logic [2:0] op;
    for (int n = 0; n < 300; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      a   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      b   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      op  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      step(v, a, b, op, rdy);
      total++; if (out_valid_o !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, out_valid_o, exp_q.size() != 0); end
      total++; if (in_ready_o !== (exp_q.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready[%0d]: got %b exp %b", n, in_ready_o, exp_q.size() < DEPTH); end
      total++; if (count_o !== 2'(exp_q.size())) begin bad++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", n, count_o, exp_q.size()); end
      total++; if (dut_head() !== exp_head()) begin bad++; $display("FAIL rnd_head[%0d]: got %h exp %h", n, dut_head(), exp_head()); end
      total++; if (illegal_o !== exp_illegal) begin bad++; $display("FAIL rnd_illegal[%0d]: got %b exp %b", n, illegal_o, exp_illegal); end
    end
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_single_push();
    test_zero_operand();
    test_fill();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Upstream operand-capture and dispatch stage for the 8-bit ALU.
- Accepts operand pairs plus an opcode from the host over a valid/ready handshake.
- Validates the opcode and buffers accepted entries in a small FIFO.
- Presents registered operands to the operation units (add/sub/and/or/modulo) with a precomputed zero-operand flag. The modulo unit uses this flag to force result 0.

Parameters:
- DATA_W, 8, operand width in bits.
- DEPTH, 2, FIFO entries; must be a power of 2 and ≥2.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- in_valid_i  input  1  host presents an operand pair.
- in_ready_o  output  1  stage can accept (FIFO not full).
- data0_i  input  DATA_W  operand A.
- data1_i  input  DATA_W  operand B.
- op_i  input  3  opcode.
- out_valid_o  output  1  head entry valid.
- out_ready_i  input  1  downstream consumes head.
- data0_o  output  DATA_W  head operand A.
- data1_o  output  DATA_W  head operand B.
- op_o  output  3  head opcode.
- zero_o  output  1  head has data0==0 or data1==0.
- illegal_o  output  1  one-cycle pulse: an illegal opcode was accepted and dropped.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_ni low, asynchronous): FIFO empties; read/write pointers = 0; in_ready_o=1; out_valid_o=0; data0_o/data1_o/op_o=0; zero_o=0; illegal_o=0; count_o=0. Reset mid-operation discards all stored entries. No partial transfer survives.
- Push: in_valid_i & in_ready_o at a clock edge.
  - Legal opcodes 0..4 (ADD, SUB, AND, OR, MOD) are written with zero flag = (data0_i==0)||(data1_i==0).
  - Opcodes 5..7 are accepted (handshake completes) but not written. illegal_o=1 the following cycle only.
- Pop: out_valid_o & out_ready_i at a clock edge. Advances the read pointer.
- in_ready_o = (count_o != DEPTH).
  - Registered or derived from count only; no combinational path from out_ready_i.
  - When full, a push is refused even if a pop occurs in the same cycle.
- out_valid_o = (count_o != 0).
  - Outputs are driven from the head entry.
  - No bypass: a push into an empty FIFO appears on the outputs on the next cycle (latency 1).
- Simultaneous legal push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
- Simultaneous illegal push and pop: count decrements; illegal_o pulses.
- Pointers wrap modulo DEPTH. count tracks 0..DEPTH exactly.
- Output fields stay stable while out_valid_o=1 and out_ready_i=0.
- When the FIFO is empty, data0_o/data1_o/op_o/zero_o hold their last values; consumers must gate on out_valid_o.

Optional Feature:
- Macro ALU_OPERAND_STATS_EN.
- When defined:
  - Adds output accepted_cnt_o (16 bits): counts legal pushes.
  - Adds output dropped_cnt_o (16 bits): counts illegal pushes.
  - Both counters reset to 0, saturate at 16'hFFFF, and do not wrap.
- When undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - DATA_W default;
  - opcode typedef op_e (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_MOD=4);
  - constant OP_LAST=4 for legality checks;
  - packed struct operand_entry_t {data0, data1, op, zero}.
- One sub-module: alu_operand_fifo, a generic DEPTH-entry synchronous FIFO of operand_entry_t providing count, full, and empty.
- The top handles opcode legality, zero-flag generation, illegal_o, and stats.

Test Plan:
- Reset then single push (data0=8'd17, data1=8'd5, op=4): out_valid_o rises next cycle; outputs 17/5/4; zero_o=0; count_o=1.
- Zero operand (data0=8'd9, data1=8'd0, op=4): zero_o=1 on the head. Then pop with out_ready_i=1: count_o returns to 0.
- Fill with out_ready_i=0, pushing (1,1,0) then (2,2,1): in_ready_o=0, count_o=2. A third push is held. On a pop the head becomes (2,2,1), and in_ready_o=1 on the next cycle.
- Illegal opcode push (op=6) into an empty FIFO: handshake completes; illegal_o pulses for exactly 1 cycle; count_o stays 0; out_valid_o stays 0.
- Streaming with out_ready_i=1 and 8 back-to-back pushes (values 0..7, op=0): first output after 1 cycle, then one per cycle in order; count_o ≤1; pointers wrap correctly.
- Assert rst_ni low asynchronously mid-stream with count_o=2: all outputs reach reset values before the next clock edge. After release, out_valid_o=0 until a new push.
